// File: rtl/lfsr16_pkg.sv
// Shared definitions for the 16-bit XNOR LFSR generator and checker,
// so both ends of the link compute bit-identical sequences.
package lfsr16_pkg;

    localparam int unsigned LFSR16_W      = 16;
    localparam logic [15:0] LFSR16_LOCKUP = 16'hFFFF;

    localparam int unsigned LFSR16_TAP_A = 15;
    localparam int unsigned LFSR16_TAP_B = 14;
    localparam int unsigned LFSR16_TAP_C = 12;
    localparam int unsigned LFSR16_TAP_D = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } lfsr16_state_e;

    // One generator step: shift left, feed back the XNOR of the taps.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        logic fb;
        fb = ~(s[LFSR16_TAP_A] ^ s[LFSR16_TAP_B] ^ s[LFSR16_TAP_C] ^ s[LFSR16_TAP_D]);
        return {s[14:0], fb};
    endfunction

endpackage

// File: rtl/lfsr16_err_counter.sv
// Saturating error counter; clear takes effect first, then the increment.
module lfsr16_err_counter #(
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] cnt
);

    logic [ERR_W-1:0] cnt_q;
    logic [ERR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end
        if (inc && (cnt_d != {ERR_W{1'b1}})) begin
            cnt_d = cnt_d + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lfsr_16_checker.sv
// PRBS checker: self-synchronises a local LFSR predictor to the incoming
// generator words, locks, then flywheels and counts mismatched words.
module lfsr_16_checker
    import lfsr16_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      expected
);

    localparam int unsigned CNT_W = 4;

    lfsr16_state_e state_q, state_d;
    logic [15:0]      pred_q, pred_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_inc_c;
    logic [CNT_W-1:0] match_inc_c;
    logic [CNT_W-1:0] miss_inc_c;

    assign match_inc_c = match_cnt_q + CNT_W'(1);
    assign miss_inc_c  = miss_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_inc_c   = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_data != LFSR16_LOCKUP) begin
                        pred_d      = lfsr16_next(in_data);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == pred_q) begin
                        pred_d      = lfsr16_next(in_data);
                        match_cnt_d = match_inc_c;
                        if (match_inc_c == CNT_W'(LOCK_CNT)) begin
                            state_d    = LOCK;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end else if (in_data == LFSR16_LOCKUP) begin
                        // Lockup word cannot seed anything useful; rehunt.
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end else begin
                        pred_d      = lfsr16_next(in_data);
                        match_cnt_d = '0;
                    end
                end
                LOCK: begin
                    pred_d = lfsr16_next(pred_q);
                    if (in_data == pred_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc_c   = 1'b1;
                        miss_cnt_d  = miss_inc_c;
                        if (miss_inc_c == CNT_W'(UNLOCK_CNT)) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            pred_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    lfsr16_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .inc (err_inc_c),
        .cnt (err_cnt)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign expected  = pred_q;

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Bench for lfsr_16_checker: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_lfsr_16_checker;

    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        err_clr;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] expected;

    lfsr_16_checker #(
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N),
        .ERR_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .expected  (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    endtask

    // Reference model: mode 0=hunting, 1=verifying, 2=locked.
    int          m_mode;
    logic [15:0] m_pred;
    int          m_match;
    int          m_miss;
    int          m_err;
    logic        m_pulse;

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        return {s[14:0], ~(^(s & 16'hD008))};
    endfunction

    function void model_reset();
        m_mode = 0; m_pred = 16'h0; m_match = 0; m_miss = 0; m_err = 0; m_pulse = 1'b0;
    endfunction

    function void model_step(input logic v, input logic [15:0] d, input logic c);
        m_pulse = 1'b0;
        if (c) m_err = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 16'hFFFF) begin
                    m_pred = ref_next(d); m_match = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_pred = ref_next(d);
                    m_match++;
                    if (m_match == LOCK_N) begin m_mode = 2; m_miss = 0; end
                end else if (d == 16'hFFFF) begin
                    m_mode = 0; m_match = 0;
                end else begin
                    m_pred = ref_next(d); m_match = 0;
                end
            end else begin
                if (d == m_pred) m_miss = 0;
                else begin
                    m_pulse = 1'b1;
                    if (m_err < 65535) m_err++;
                    m_miss++;
                    if (m_miss == UNLOCK_N) begin m_mode = 0; m_match = 0; m_miss = 0; end
                end
                m_pred = ref_next(m_pred);
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".locked"},    32'(locked),    32'(m_mode == 2));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
        check({tag, ".expected"},  32'(expected),  32'(m_pred));
    endtask

    // Apply one cycle of stimulus, update the model, sample #1 after the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic c, input string tag);
        @(negedge clk);
        in_valid = v; in_data = d; err_clr = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        compare_model(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c;
        logic        e_locked;
        logic        e_pulse;
        logic [15:0] e_err;
        logic [15:0] e_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].c, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.locked", i),    32'(locked),    32'(vecs[i].e_locked));
            check($sformatf("vec%0d.err_pulse", i), 32'(err_pulse), 32'(vecs[i].e_pulse));
            check($sformatf("vec%0d.err_cnt", i),   32'(err_cnt),   32'(vecs[i].e_err));
            check($sformatf("vec%0d.expected", i),  32'(expected),  32'(vecs[i].e_exp));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0003};
        vecs[1] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0007};
        vecs[2] = '{1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'd0, 16'h000F};
        vecs[3] = '{1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 16'd0, 16'h001E};
        vecs[4] = '{1'b1, 16'h001E, 1'b0, 1'b1, 1'b0, 16'd0, 16'h003C};
        vecs[5] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'd1, 16'h0078};
        vecs[6] = '{1'b1, 16'h0078, 1'b0, 1'b1, 1'b0, 16'd1, 16'h00F0};
        vecs[7] = '{1'b1, 16'h00F0, 1'b0, 1'b1, 1'b0, 16'd1, 16'h01E1};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        model_reset();
        #12;
        check("reset.locked",    32'(locked),    32'd0);
        check("reset.err_pulse", 32'(err_pulse), 32'd0);
        check("reset.err_cnt",   32'(err_cnt),   32'd0);
        check("reset.expected",  32'(expected),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Acquire, then flywheel over one corrupted word.
        run_vecs(0, 7);

        // Unlock after three consecutive wrong words.
        apply_reset();
        run_vecs(0, 4);
        step(1'b1, 16'h1234, 1'b0, "unlock1");
        check("unlock1.pulse", 32'(err_pulse), 32'd1);
        step(1'b1, 16'h1234, 1'b0, "unlock2");
        check("unlock2.locked", 32'(locked), 32'd1);
        step(1'b1, 16'h1234, 1'b0, "unlock3");
        check("unlock3.pulse",  32'(err_pulse), 32'd1);
        check("unlock3.err",    32'(err_cnt),   32'd3);
        check("unlock3.locked", 32'(locked),    32'd0);

        // Lockup words ignored in HUNT, then seed and reseed in VERIFY.
        step(1'b1, 16'hFFFF, 1'b0, "lockup1");
        check("lockup1.expected", 32'(expected), 32'h01E1);
        step(1'b1, 16'hFFFF, 1'b0, "lockup2");
        check("lockup2.expected", 32'(expected), 32'h01E1);
        step(1'b1, 16'h0001, 1'b0, "seed");
        check("seed.expected", 32'(expected), 32'h0003);
        step(1'b1, 16'h0005, 1'b0, "reseed");
        check("reseed.expected", 32'(expected), 32'h000B);
        check("reseed.err",      32'(err_cnt),  32'd3);
        check("reseed.pulse",    32'(err_pulse), 32'd0);
        step(1'b0, 16'h000B, 1'b0, "idle");
        check("idle.expected", 32'(expected), 32'h000B);

        // Clear colliding with a locked mismatch.
        apply_reset();
        run_vecs(0, 4);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, m_pred ^ 16'h0001, 1'b0, "miss");
            step(1'b1, m_pred, 1'b0, "hit");
        end
        check("clr.pre_err", 32'(err_cnt), 32'd5);
        step(1'b1, m_pred ^ 16'h8000, 1'b1, "clr_collide");
        check("clr_collide.err",   32'(err_cnt),   32'd1);
        check("clr_collide.pulse", 32'(err_pulse), 32'd1);
        step(1'b0, 16'h0000, 1'b1, "clr_alone");
        check("clr_alone.err",    32'(err_cnt), 32'd0);
        check("clr_alone.locked", 32'(locked),  32'd1);

        // Async reset between edges while locked with errors pending.
        step(1'b1, m_pred ^ 16'h0100, 1'b0, "pre_rst");
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async.locked",   32'(locked),   32'd0);
        check("async.err_cnt",  32'(err_cnt),  32'd0);
        check("async.expected", 32'(expected), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_vecs(0, 4);

        // Randomized traffic against the model.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            logic        v;
            logic        c;
            logic [15:0] d;
            v = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 19) == 0);
            if (m_mode != 0 && $urandom_range(0, 9) < 8) d = m_pred;
            else if ($urandom_range(0, 30) == 0)          d = 16'hFFFF;
            else                                          d = 16'($urandom);
            step(v, d, c, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
